// File: rtl/pdm_playback_serializer.sv
// Loopback path from the PDM deserializer to the audio pin: buffers whole words in a
// small FIFO and replays them MSB-first, one bit every BIT_DIV clocks.
module pdm_playback_serializer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 50
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic                        enable_i,
  input  logic                        valid_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        clear_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        full_o,
  output logic                        overflow_o,
  output logic                        underflow_o,
  output logic                        audio_pwm_o,
  output logic                        audio_sd_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(BIT_DIV);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PLAY} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer;
  logic              tick;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bits_left;
  logic [LW-1:0]     level_nxt;
  logic              push, pop, shift_en, starve, drop, pwm_nxt;

  assign tick      = (timer == TW'(BIT_DIV - 1));
  assign head      = mem[rd_ptr];
  assign push      = enable_i && valid_i && ((level_o < LW'(FIFO_DEPTH)) || pop);
  assign drop      = enable_i && valid_i && !push;
  assign level_nxt = level_o + LW'(push) - LW'(pop);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // shift_q holds the bits still to be played, left-aligned; the bit on the pin
  // is already stripped off, so a load drives the MSB and stores the remainder.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift_en  = 1'b0;
    starve    = 1'b0;
    pwm_nxt   = audio_pwm_o;
    case (state)
      ST_IDLE: begin
        pwm_nxt   = 1'b0;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        pwm_nxt = 1'b0;
        if (tick && level_o != '0) begin
          pop       = 1'b1;
          pwm_nxt   = head[DATA_W-1];
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (bits_left != '0) begin
            shift_en = 1'b1;
            pwm_nxt  = shift_q[DATA_W-1];
          end else if (level_o != '0) begin
            pop     = 1'b1;
            pwm_nxt = head[DATA_W-1];
          end else begin
            starve    = 1'b1;
            pwm_nxt   = 1'b0;
            state_nxt = ST_WAIT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable_i) begin
      state_nxt = ST_IDLE;
      pop       = 1'b0;
      shift_en  = 1'b0;
      starve    = 1'b0;
      pwm_nxt   = 1'b0;
    end
  end

  // Dropping enable flushes the FIFO and discards any partially played word.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      full_o      <= 1'b0;
      shift_q     <= '0;
      bits_left   <= '0;
      audio_pwm_o <= 1'b0;
      audio_sd_o  <= 1'b0;
    end else begin
      audio_pwm_o <= pwm_nxt;
      audio_sd_o  <= enable_i;
      if (!enable_i) begin
        timer     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level_o   <= '0;
        full_o    <= 1'b0;
        shift_q   <= '0;
        bits_left <= '0;
      end else begin
        timer   <= tick ? '0 : timer + TW'(1);
        level_o <= level_nxt;
        full_o  <= (level_nxt == LW'(FIFO_DEPTH));
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr    <= rd_ptr + PW'(1);
          shift_q   <= {head[DATA_W-2:0], 1'b0};
          bits_left <= BW'(DATA_W - 1);
        end else if (shift_en) begin
          shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
          bits_left <= bits_left - BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // A set event in the same cycle as clear_i wins.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (drop)         overflow_o  <= 1'b1;
      else if (clear_i) overflow_o  <= 1'b0;
      if (starve)       underflow_o <= 1'b1;
      else if (clear_i) underflow_o <= 1'b0;
    end
  end

endmodule
